pic_alu_acc: RTL and testbench



---
 rtl/pic_demo_pkg.sv | 17 +
 rtl/pic_alu_core.sv | 61 ++++++
 rtl/pic_alu_acc.sv | 96 +++++++++
 tb/tb_pic_alu_acc.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pic_demo_pkg.sv
// Shared types and helpers for the PIC demo arithmetic datapath.
package pic_demo_pkg;

  typedef enum logic [2:0] {
    OP_INV  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_ACC  = 3'd3,
    OP_LOAD = 3'd4
  } pic_op_t;

  // Channel-index width; never narrower than one bit so ports stay legal.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pic_alu_core.sv
// Combinational arithmetic for one request: result, raw carry/borrow and the
// accumulator write-back value, with optional clamping.
module pic_alu_core
  import pic_demo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  pic_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             acc_we,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum_ab;
  logic [WIDTH:0] diff_ab;
  logic [WIDTH:0] sum_acc;

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} - {1'b0, b};
  assign sum_acc = {1'b0, acc_in} + {1'b0, a};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    acc_we   = 1'b0;
    acc_next = acc_in;
    case (op)
      OP_INV: result = ~a;
      OP_ADD: begin
        carry  = sum_ab[WIDTH];
        result = (SATURATE != 0 && carry) ? '1 : sum_ab[WIDTH-1:0];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        carry  = diff_ab[WIDTH];
        result = (SATURATE != 0 && carry) ? '0 : diff_ab[WIDTH-1:0];
      end
      OP_ACC: begin
        carry    = sum_acc[WIDTH];
        result   = (SATURATE != 0 && carry) ? '1 : sum_acc[WIDTH-1:0];
        acc_we   = 1'b1;
        acc_next = result;
      end
      OP_LOAD: begin
        result   = a;
        acc_we   = 1'b1;
        acc_next = a;
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pic_alu_acc.sv
// Arithmetic block with per-channel accumulators and a registered
// valid/ready output stage.
module pic_alu_acc
  import pic_demo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  localparam int CW      = ch_width(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [CW-1:0]    in_ch,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic [CW-1:0]    out_ch
);

  // Handshake: a transfer happens on a side when its valid and ready are both
  // high at a rising edge; in_ready depends only on rst and the output stage.
  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_carry_q, out_carry_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;

  logic             accept;
  logic [CW-1:0]    ch_sel;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_acc_we;
  logic [WIDTH-1:0] core_acc_next;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // With a single channel the 1-bit index is forced to the only entry.
  assign ch_sel   = (CHANNELS == 1) ? '0 : in_ch;

  pic_alu_core #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_core (
    .op      (pic_op_t'(in_op)),
    .a       (in_a),
    .b       (in_b),
    .acc_in  (acc_q[ch_sel]),
    .result  (core_result),
    .carry   (core_carry),
    .acc_we  (core_acc_we),
    .acc_next(core_acc_next)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_carry_d = out_carry_q;
    out_ch_d    = out_ch_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = core_result;
      out_carry_d = core_carry;
      out_ch_d    = in_ch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_ch_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_carry_q <= out_carry_d;
      out_ch_q    <= out_ch_d;
      if (accept && core_acc_we) acc_q[ch_sel] <= core_acc_next;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_pic_alu_acc.sv
// Directed bench: a wrapping and a saturating instance share one stimulus.
module tb_pic_alu_acc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_op;
  logic [1:0] in_ch;
  logic [7:0] in_a, in_b;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_carry0;
  logic [7:0] out_data0;
  logic [1:0] out_ch0;
  logic       in_ready1, out_valid1, out_carry1;
  logic [7:0] out_data1;
  logic [1:0] out_ch1;

  int n_cmp  = 0;
  int n_fail = 0;

  pic_alu_acc #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_carry(out_carry0), .out_ch(out_ch0)
  );

  pic_alu_acc #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_carry(out_carry1), .out_ch(out_ch1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] ch;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       c0;
    logic       c1;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] ch,
                       input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_op    = op;
    in_ch    = ch;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [7:0] d0,
                           input logic [7:0] d1, input logic c0, input logic c1,
                           input logic [1:0] ch);
    check({name, " valid0"}, {31'd0, out_valid0}, {31'd0, v});
    check({name, " valid1"}, {31'd0, out_valid1}, {31'd0, v});
    check({name, " data0"}, {24'd0, out_data0}, {24'd0, d0});
    check({name, " data1"}, {24'd0, out_data1}, {24'd0, d1});
    check({name, " carry0"}, {31'd0, out_carry0}, {31'd0, c0});
    check({name, " carry1"}, {31'd0, out_carry1}, {31'd0, c1});
    check({name, " ch0"}, {30'd0, out_ch0}, {30'd0, ch});
    check({name, " ch1"}, {30'd0, out_ch1}, {30'd0, ch});
  endtask

  initial begin
    //          op    ch     a      b      d0     d1     c0    c1
    vecs[0]  = '{3'd0, 2'd0, 8'h5A, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 2'd0, 8'hF0, 8'h20, 8'h10, 8'hFF, 1'b1, 1'b1};
    vecs[2]  = '{3'd2, 2'd0, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{3'd4, 2'd1, 8'h10, 8'h00, 8'h10, 8'h10, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 2'd1, 8'h05, 8'h00, 8'h15, 8'h15, 1'b0, 1'b0};
    vecs[5]  = '{3'd3, 2'd2, 8'h01, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[6]  = '{3'd1, 2'd0, 8'h12, 8'h34, 8'h46, 8'h46, 1'b0, 1'b0};
    vecs[7]  = '{3'd2, 2'd0, 8'h05, 8'h03, 8'h02, 8'h02, 1'b0, 1'b0};
    vecs[8]  = '{3'd4, 2'd3, 8'hF0, 8'h00, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vecs[9]  = '{3'd3, 2'd3, 8'h20, 8'h00, 8'h10, 8'hFF, 1'b1, 1'b1};
    vecs[10] = '{3'd3, 2'd3, 8'h01, 8'h00, 8'h11, 8'hFF, 1'b0, 1'b1};
    vecs[11] = '{3'd5, 2'd2, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{3'd3, 2'd1, 8'h01, 8'h00, 8'h16, 8'h16, 1'b0, 1'b0};
    vecs[13] = '{3'd2, 2'd0, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{3'd1, 2'd0, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b1, 1'b1};
    vecs[15] = '{3'd0, 2'd0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0};

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 2'd0, 8'h11, 8'h22);
    step();
    step();
    check("rst in_ready0", {31'd0, in_ready0}, 32'd0);
    check("rst in_ready1", {31'd0, in_ready1}, 32'd0);
    check_out("rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    drive(1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
    step();
    check_out("idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);

    // back-to-back vectors, one per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].ch, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d in_ready0", i), {31'd0, in_ready0}, 32'd1);
      check($sformatf("v%0d in_ready1", i), {31'd0, in_ready1}, 32'd1);
      step();
      check_out($sformatf("v%0d", i), 1'b1, vecs[i].d0, vecs[i].d1,
                vecs[i].c0, vecs[i].c1, vecs[i].ch);
    end
    drive(1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
    step();
    check_out("drain", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 2'd0);

    // stall: queued ACC must not touch the accumulator until accepted
    drive(1'b1, 3'd1, 2'd1, 8'h01, 8'h01);
    step();
    check_out("pre-stall", 1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 2'd1);
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 2'd2, 8'h03, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d in_ready0", k), {31'd0, in_ready0}, 32'd0);
      check($sformatf("stall%0d in_ready1", k), {31'd0, in_ready1}, 32'd0);
      step();
      check_out($sformatf("stall%0d", k), 1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready0", {31'd0, in_ready0}, 32'd1);
    step();
    check_out("release", 1'b1, 8'h04, 8'h04, 1'b0, 1'b0, 2'd2);
    drive(1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
    step();
    check_out("post-stall", 1'b0, 8'h04, 8'h04, 1'b0, 1'b0, 2'd2);

    // reset with a pending output and a live request
    drive(1'b1, 3'd4, 2'd0, 8'h07, 8'h00);
    step();
    check_out("load ch0", 1'b1, 8'h07, 8'h07, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    drive(1'b1, 3'd3, 2'd0, 8'h01, 8'h00);
    #1;
    check("midrst in_ready0", {31'd0, in_ready0}, 32'd0);
    step();
    check_out("midrst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    step();
    check_out("after rst", 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
    step();
    check_out("end", 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
